// File: rtl/dac_pkg.sv
// Shared types and helpers for the multi-channel DAC DDR stream driver.
package dac_pkg;

  typedef enum logic [1:0] {IDLE, FILL, ACTIVE, DRAIN} dac_state_e;

  localparam logic [1:0] TP_STREAM = 2'd0;
  localparam logic [1:0] TP_RAMP   = 2'd1;
  localparam logic [1:0] TP_SQUARE = 2'd2;

  // Two's-complement zero after the format map, zero-extended to 32 bits.
  function automatic logic [31:0] midscale(input int width, input logic offset_bin);
    return offset_bin ? (32'd1 << (width - 1)) : 32'd0;
  endfunction

  // Offset binary is two's complement with the sample MSB inverted.
  function automatic logic [31:0] fmt_map(input logic [31:0] sample, input int width,
                                          input logic offset_bin);
    return sample ^ midscale(width, offset_bin);
  endfunction

endpackage

// File: rtl/dac_oddr_bus.sv
// WIDTH-bit bank of ODDR2-equivalent cells: D0 on the rising edge of C0 (clk),
// D1 on the rising edge of C1 (inverted clk), pin follows the most recent edge.
module dac_oddr_bus #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             r,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] q
);

  logic c1;
  assign c1 = ~clk;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic q_rise;
    logic q_fall;

    always_ff @(posedge clk) begin
      if (r) q_rise <= 1'b0;
      else   q_rise <= d0[b];
    end

    always_ff @(posedge c1) begin
      if (r) q_fall <= 1'b0;
      else   q_fall <= d1[b];
    end

    assign q[b] = clk ? q_rise : q_fall;
  end

endmodule

// File: rtl/dac_ddr_stream.sv
// Multi-channel valid/ready DAC stream driver with DDR pin output.
// Optional test patterns are built when DAC_TEST_PATTERN_EN is defined.
module dac_ddr_stream
  import dac_pkg::*;
#(
  parameter int WIDTH        = 14,
  parameter int CHANNELS     = 2,
  parameter int DDR_MODE     = 0,
  parameter int PIPE         = 1,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       fmt_offset_bin,
`ifdef DAC_TEST_PATTERN_EN
  input  logic [1:0]                 tp_sel,
`endif
  input  logic                       in_valid,
  input  logic [CHANNELS*WIDTH-1:0]  in_data,
  output logic                       in_ready,
  output logic                       active,
  output logic [CNT_W-1:0]           underrun_cnt,
  output logic [(DDR_MODE != 0 ? CHANNELS/2 : CHANNELS)*WIDTH-1:0] out
);

  localparam int NB  = (DDR_MODE != 0) ? CHANNELS / 2 : CHANNELS;
  localparam int DCW = $clog2(DRAIN_CYCLES) + 1;

  dac_state_e            state;
  logic [DCW-1:0]        drain_cnt;
  logic [CHANNELS*WIDTH-1:0] held;
  logic [WIDTH-1:0]      ms_code;
  logic [WIDTH-1:0]      sel_word [CHANNELS];
  logic [WIDTH-1:0]      cap_next [CHANNELS];
  logic [WIDTH-1:0]      pipe     [PIPE+1][CHANNELS];
  logic                  use_mid;
  logic                  pattern_mode;
  logic                  xfer;
  logic                  live;
  logic                  underrun;

  // en qualifies the handshake so a word offered while the stream is closing is left untouched.
  assign xfer     = in_valid & in_ready & en;
  assign live     = (state == ACTIVE) & en;
  assign underrun = live & ~in_valid & ~pattern_mode;
  assign ms_code  = WIDTH'(midscale(WIDTH, fmt_offset_bin));

`ifdef DAC_TEST_PATTERN_EN
  localparam logic [WIDTH-1:0] SQ_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SQ_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] ramp_cnt;
  logic [3:0]       sq_cnt;
  logic [WIDTH-1:0] pat_word [CHANNELS];

  assign pattern_mode = (tp_sel == TP_RAMP) || (tp_sel == TP_SQUARE);

  always_ff @(posedge clk) begin
    if (reset) begin
      ramp_cnt <= '0;
      sq_cnt   <= '0;
    end else if (live) begin
      ramp_cnt <= ramp_cnt + WIDTH'(1);
      sq_cnt   <= sq_cnt + 4'd1;
    end
  end

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      if (tp_sel == TP_RAMP) pat_word[k] = ramp_cnt + (WIDTH'(k) << (WIDTH - 3));
      else                   pat_word[k] = sq_cnt[3] ? SQ_NEG : SQ_POS;
    end
  end
`else
  assign pattern_mode = 1'b0;
`endif

  // Capture source: fresh word, held word on underrun, pattern, or midscale otherwise.
  always_comb begin
    use_mid = 1'b1;
    for (int k = 0; k < CHANNELS; k++) sel_word[k] = held[k*WIDTH +: WIDTH];
    if (pattern_mode) begin
`ifdef DAC_TEST_PATTERN_EN
      if (live) begin
        use_mid = 1'b0;
        for (int k = 0; k < CHANNELS; k++) sel_word[k] = pat_word[k];
      end
`endif
    end else if (xfer) begin
      use_mid = 1'b0;
      for (int k = 0; k < CHANNELS; k++) sel_word[k] = in_data[k*WIDTH +: WIDTH];
    end else if (live) begin
      use_mid = 1'b0;
    end
    for (int k = 0; k < CHANNELS; k++)
      cap_next[k] = use_mid ? ms_code
                            : WIDTH'(fmt_map(32'(sel_word[k]), WIDTH, fmt_offset_bin));
  end

  // Enable sequencer; in_ready and active are registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      drain_cnt <= '0;
      in_ready  <= 1'b0;
      active    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state    <= FILL;
            in_ready <= 1'b1;
          end
        end
        FILL: begin
          if (!en) begin
            state    <= IDLE;
            in_ready <= 1'b0;
          end else if (xfer) begin
            state  <= ACTIVE;
            active <= 1'b1;
          end
        end
        ACTIVE: begin
          if (!en) begin
            state     <= DRAIN;
            drain_cnt <= '0;
            in_ready  <= 1'b0;
            active    <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain_cnt == DCW'(DRAIN_CYCLES - 1)) begin
            state    <= en ? FILL : IDLE;
            in_ready <= en;
          end else begin
            drain_cnt <= drain_cnt + DCW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          active   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      held         <= '0;
      underrun_cnt <= '0;
    end else begin
      if (xfer && !pattern_mode) held <= in_data;
      if (underrun && underrun_cnt != '1) underrun_cnt <= underrun_cnt + CNT_W'(1);
    end
  end

  // Stage 0 is the capture register; stage PIPE feeds the ODDR D inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s <= PIPE; s++)
        for (int k = 0; k < CHANNELS; k++) pipe[s][k] <= ms_code;
    end else begin
      for (int k = 0; k < CHANNELS; k++) pipe[0][k] <= cap_next[k];
      for (int s = 1; s <= PIPE; s++)
        for (int k = 0; k < CHANNELS; k++) pipe[s][k] <= pipe[s-1][k];
    end
  end

  for (genvar j = 0; j < NB; j++) begin : g_bus
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;

    if (DDR_MODE != 0) begin : g_pair
      assign d0 = pipe[PIPE][2*j];
      assign d1 = pipe[PIPE][2*j+1];
    end else begin : g_repl
      assign d0 = pipe[PIPE][j];
      assign d1 = pipe[PIPE][j];
    end

    dac_oddr_bus #(.WIDTH(WIDTH)) u_bus (
      .clk (clk),
      .r   (1'b0),
      .d0  (d0),
      .d1  (d1),
      .q   (out[j*WIDTH +: WIDTH])
    );
  end

endmodule

// File: doc/dac_ddr_stream.md
Name: dac_ddr_stream

Overview:
Multi-channel, parametrised successor to the single-bus DAC pin driver. It accepts a valid/ready sample stream for CHANNELS DAC channels and applies format conversion. It drives the DAC pins through per-bit ODDR2 primitives, either replicating each sample on both clock edges or interleaving channel pairs (even channel on the rising half, odd channel on the falling half). An enable state machine gives glitch-free start and midscale drain on stop, holds the last sample on underrun, and counts underruns.

Parameters:
WIDTH, 14, bits per DAC sample
CHANNELS, 2, number of logical channels; must be even when DDR_MODE=1
DDR_MODE, 0, 0 = replicate (one pin bus per channel), 1 = interleave pairs (one pin bus per channel pair)
PIPE, 1, register stages between the capture register and the ODDR D inputs; minimum 1
DRAIN_CYCLES, 4, midscale cycles emitted after en falls
CNT_W, 16, underrun counter width

Ports:
clk  in  1  DAC sample clock; the ODDR C1 input is its inversion
reset  in  1  synchronous, active-high
en  in  1  stream enable, active high
fmt_offset_bin  in  1  0 = two's complement output, 1 = offset binary output (MSB inverted); sampled every cycle
in_valid  in  1  sample word valid
in_data  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH], two's complement
in_ready  out  1  high in FILL and ACTIVE
active  out  1  high in ACTIVE
underrun_cnt  out  CNT_W  saturating underrun count
out  out  NB*WIDTH  DAC pins; NB = CHANNELS when DDR_MODE=0, CHANNELS/2 when DDR_MODE=1

Behaviour:
- Reset: state=IDLE, in_ready=0, active=0, underrun_cnt=0, held sample = 0, pipeline filled with midscale.
- Midscale is two's-complement 0. After the format map it is 0 (fmt=0) or 1<<(WIDTH-1) (fmt=1).
- States:
  - IDLE -> FILL when en=1.
  - FILL -> ACTIVE on the first in_valid&in_ready; that word is captured. FILL -> IDLE if en=0; a word with valid high in the same cycle is not consumed.
  - ACTIVE -> DRAIN when en=0. Any word presented in that cycle is not consumed (in_ready registered low from this cycle).
  - DRAIN counts DRAIN_CYCLES cycles, then moves to IDLE, or to FILL if en=1 at the terminal count. en re-asserted mid-drain does not shorten the drain.
- Handshake: a word transfers when in_valid & in_ready at the rising edge. in_ready is a registered function of state only, not combinational from in_valid.
- Underrun: in ACTIVE with in_valid=0, the held sample is repeated and underrun_cnt increments. The counter saturates at all-ones and clears only on reset.
- Capture register content: the new word on a transfer, midscale in IDLE/FILL/DRAIN, the held word on underrun.
- Format map is applied at capture.
- Latency: a word captured at edge N reaches the ODDR D0/D1 inputs after edge N+PIPE, and the pins show it during cycle N+PIPE+1.
- DDR_MODE=0: D0=D1=channel k on bus k.
- DDR_MODE=1: bus j has D0 = channel 2j and D1 = channel 2j+1.
- ODDR2 reset pin is tied 0. Muting is done in the datapath with midscale, never by forcing the pins to 0.
- Reset mid-stream: IDLE next cycle. Pins reach midscale within PIPE+1 cycles with no intermediate non-midscale code.

Optional Feature:
- DAC_TEST_PATTERN_EN defined: adds input port tp_sel[1:0], sampled at capture.
  - 0 = stream.
  - 1 = ramp: a per-channel WIDTH-bit counter, +1 per cycle in ACTIVE, wrapping; channel k is offset by k<<(WIDTH-3).
  - 2 = full-scale square: a channel toggles between max positive and max negative every 8 cycles.
  - In patterns 1 and 2, in_ready stays as defined by the state and input words are consumed and discarded. The underrun counter is frozen.
- Undefined: no tp_sel port; stream only.

Decomposition:
- Package dac_pkg: state enum (IDLE, FILL, ACTIVE, DRAIN), midscale function, format-map function, tp_sel encodings.
- One sub-module, dac_oddr_bus: a WIDTH-bit ODDR2 bank with d0/d1 vector inputs, instantiated NB times.

Test Plan:
- Reset, then en=1 with valid samples 0x0100/0x3F00 (CHANNELS=2, DDR_MODE=0, fmt=0) -> first word accepted, active=1. bus0=0x0100 and bus1=0x3F00 on both halves PIPE+1 cycles after transfer.
- DDR_MODE=1, fmt=1, ch0=0x0000, ch1=0x1FFF -> pins 0x2000 on the rising half and 0x3FFF on the falling half.
- In ACTIVE, drop in_valid for 3 cycles -> held word repeated, underrun_cnt=3. Preset the counter to 0xFFFE plus 3 underruns -> reads 0xFFFF.
- en falls in ACTIVE -> in_ready low next cycle, midscale for exactly DRAIN_CYCLES=4, IDLE. en re-raised at drain cycle 2 -> FILL after 4 cycles.
- reset asserted mid-stream with pins at 0x1234 -> midscale within PIPE+1 cycles, all outputs at reset values.
- DAC_TEST_PATTERN_EN, tp_sel=1 -> ch0 ramp 0,1,2,…; after 2^WIDTH cycles it wraps to 0. ch1 = ch0 + 0x800 (WIDTH=14).
